// File: rtl/matrix_keypad_scanner.sv
// Row/column matrix keypad scanner: two-flop row synchroniser, press/release
// debounce, column scan with lowest-column/lowest-row priority, and a small
// key-code FIFO read through a valid/ready handshake.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-push the held key code
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Each column is driven for SETTLE+2 cycles before its rows are sampled: two
// cycles flush the synchroniser, then rows are seen stable for SETTLE cycles.
// Exact latency from a row edge (applied just after clock edge 0) to the FIFO
// push edge: 3 + DEBOUNCE + (c+1)*(SETTLE+2) + 1 edges; key_valid_o is high
// right after that edge. Defaults give 20 edges for a key in column 2.
module matrix_keypad_scanner #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
`ifdef KEYPAD_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY  = 32,
  parameter int unsigned REPEAT_PERIOD = 8,
`endif
  parameter int unsigned CODE_W        = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_i,
  output logic [COLS-1:0]   col_o,
  output logic [CODE_W-1:0] key_code_o,
  output logic              key_valid_o,
  input  logic              key_ready_i,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam int unsigned StW  = $clog2(SETTLE + 2);
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = AddrW + 1;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW = $clog2(RepMax + 1);
`endif

  typedef enum logic [1:0] {StIdle, StDebPress, StScan, StHold} state_e;

  logic [ROWS-1:0]   sync1_q, rs_q;
  logic              any;
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ColW-1:0]   c_q, c_d;
  logic [StW-1:0]    settle_q, settle_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              push_q, push_d;
  logic [RowW-1:0]   row_idx;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [RepW-1:0]   rep_q, rep_d;
  logic              rep_first_q, rep_first_d;
`endif

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic              empty, full, pop, push_ok;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      rs_q    <= '0;
    end else begin
      sync1_q <= row_i;
      rs_q    <= sync1_q;
    end
  end

  assign any = |rs_q;

  // Lowest set row wins within the sampled column.
  always_comb begin
    row_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rs_q[i]) row_idx = RowW'(i);
    end
  end

  // Scanner state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      c_q         <= '0;
      settle_q    <= '0;
      code_q      <= '0;
      push_q      <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      settle_q    <= settle_d;
      code_q      <= code_d;
      push_q      <= push_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  // Next-state, column drive and push request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    settle_d    = settle_q;
    code_d      = code_q;
    push_d      = 1'b0;
    col_o       = '1;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d = StDebPress;
          cnt_d   = '0;
        end
      end
      StDebPress: begin
        if (!any) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
          state_d  = StScan;
          c_d      = '0;
          settle_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        col_o = COLS'(1) << c_q;
        if (settle_q != StW'(SETTLE + 1)) begin
          settle_d = settle_q + 1'b1;
        end else if (any) begin
          code_d  = CODE_W'(32'(row_idx) * COLS + 32'(c_q));
          push_d  = 1'b1;
          state_d = StHold;
          cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
`endif
        end else if (c_q != ColW'(COLS - 1)) begin
          c_d      = c_q + 1'b1;
          settle_d = '0;
        end else begin
          // Key released before any column saw it.
          state_d = StIdle;
        end
      end
      StHold: begin
        if (any) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer only runs while the key is continuously held.
        if (any) begin
          if (rep_q == (rep_first_q ? RepW'(REPEAT_DELAY - 1) : RepW'(REPEAT_PERIOD - 1))) begin
            push_d      = 1'b1;
            rep_d       = '0;
            rep_first_d = 1'b0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rep_d       = '0;
          rep_first_d = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

  // FIFO control: a full FIFO still accepts a push when the head pops in the same cycle.
  assign empty   = (wptr_q == rptr_q);
  assign full    = ((wptr_q ^ rptr_q) == {1'b1, {AddrW{1'b0}}});
  assign pop     = key_valid_o & key_ready_i;
  assign push_ok = push_q & (~full | pop);

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push_q && full && !pop) overflow_o <= 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= code_q;
  end

  assign key_valid_o = ~empty;
  assign key_code_o  = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with a 4x4 keypad model.
module tb_matrix_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_ready, overflow, busy;
  logic [15:0] keys;
  logic [3:0]  glitch_row;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Keypad model: a pressed key connects its column drive onto its row line.
  always_comb begin
    row = glitch_row;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) row[r] = 1'b1;
  end

  matrix_keypad_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .row_i       (row),
    .col_o       (col),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_ready_i (key_ready),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!key_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; keys = '0; glitch_row = '0; key_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (20) tick();
    checks++; if (col !== 4'b1111) begin errors++; $display("FAIL reset_col got %b want 1111", col); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
  endtask

  task automatic test_single_press();
    int n;
    keys[10] = 1'b1;
    wait_valid(n);
    checks++; if (n != 20) begin errors++; $display("FAIL press_latency got %0d want 20", n); end
    checks++; if (key_code !== 4'd10) begin errors++; $display("FAIL press_code got %0d want 10", key_code); end
    repeat (20) tick();
    keys = '0;
    tick();
    wait_idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL press_release_busy got %b want 0", busy); end
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd10) begin
      errors++; $display("FAIL press_held_code got %b/%0d want 1/10", key_valid, key_code);
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pop_valid got %b want 0", key_valid); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL press_empty_code got %0d want 0", key_code); end
  endtask

  task automatic test_glitch();
    logic saw_busy = 1'b0;
    glitch_row = 4'b0001;
    repeat (3) begin tick(); saw_busy |= busy; end
    glitch_row = '0;
    repeat (12) begin tick(); saw_busy |= busy; end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_debounce got %b want 1", saw_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL glitch_push got %b want 0", key_valid); end
  endtask

  task automatic test_multi_key();
    int n;
    keys[7] = 1'b1; keys[9] = 1'b1;
    wait_valid(n);
    checks++; if (n != 16) begin errors++; $display("FAIL multi_latency got %0d want 16", n); end
    checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL multi_code got %0d want 9", key_code); end
    repeat (10) tick();
    keys = '0;
    tick();
    wait_idle();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_single got %b want 0", key_valid); end
  endtask

  task automatic test_overflow();
    int codes [5] = '{0, 5, 10, 15, 3};
    for (int i = 0; i < 5; i++) begin
      keys = 16'(1) << codes[i];
      repeat (30) tick();
      keys = '0;
      tick();
      wait_idle();
      if (i == 3) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(codes[i])) begin
        errors++; $display("FAIL ovf_drain%0d got %b/%0d want 1/%0d", i, key_valid, key_code, codes[i]);
      end
      key_ready = 1'b1; tick(); key_ready = 1'b0;
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", key_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_scan();
    keys[3] = 1'b1;
    repeat (17) tick();
    checks++; if (col !== 4'b0100 || busy !== 1'b1) begin
      errors++; $display("FAIL midscan_col got %b/%b want 0100/1", col, busy);
    end
    reset = 1'b1;
    #1;
    checks++; if (col !== 4'b1111) begin errors++; $display("FAIL midscan_reset_col got %b want 1111", col); end
    checks++; if (busy !== 1'b0 || key_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midscan_reset_state got %b%b%b want 000", busy, key_valid, overflow);
    end
    tick();
    keys = '0;
    reset = 1'b0;
    repeat (30) tick();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midscan_no_code got %b want 0", key_valid); end
  endtask

  task automatic test_full_and_pop();
    int exp [4] = '{2, 3, 4, 0};
    for (int i = 1; i <= 4; i++) begin
      keys = 16'(1) << i;
      repeat (30) tick();
      keys = '0;
      tick();
      wait_idle();
    end
    // Code 0 pushes on edge 12 after the press; pop the head on that same edge.
    keys[0] = 1'b1;
    repeat (11) tick();
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
    keys = '0;
    tick();
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(exp[i])) begin
        errors++; $display("FAIL fullpop_drain%0d got %b/%0d want 1/%0d", i, key_valid, key_code, exp[i]);
      end
      key_ready = 1'b1; tick(); key_ready = 1'b0;
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b want 0", key_valid); end
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int seen [$];
    int exp [4] = '{20, 52, 60, 68};
    key_ready = 1'b1;
    keys[6] = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t == 70) keys = '0;
      if (key_valid && key_code == 4'd6) seen.push_back(t);
    end
    key_ready = 1'b0;
    checks++; if (seen.size() != 4) begin errors++; $display("FAIL repeat_count got %0d want 4", seen.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= seen.size() || seen[i] != exp[i]) begin
        errors++; $display("FAIL repeat_edge%0d got %0d want %0d", i, (i < seen.size()) ? seen[i] : -1, exp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_key();
    test_overflow();
    test_reset_mid_scan();
    test_full_and_pop();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_keypad_scanner.md
Name: matrix_keypad_scanner

Overview:
Parametrised row/column matrix keypad scanner with row synchroniser, press/release debounce and a per-column scan FIFO-buffered key-code output.
- Drives columns, samples rows, encodes the pressed key as row_index*COLS + col_index, and queues codes in a small FIFO read through a valid/ready handshake.
- Sits between the keypad pins and the host/control logic; a wider keyboard matrix is supported through the parameters.

Parameters:
- ROWS, 4, number of row inputs (2..16)
- COLS, 4, number of column outputs (2..16)
- SETTLE, 2, cycles a single column is driven before its rows are sampled (>=1)
- DEBOUNCE, 4, consecutive identical synchronised samples required to accept a press or a release (>=1)
- FIFO_DEPTH, 4, key-code queue depth (power of 2, >=2)
- CODE_W, $clog2(ROWS*COLS), key-code width (derived; do not override)

Ports:
- clock, input, 1, system clock, rising edge
- reset, input, 1, asynchronous active-high reset
- row, input, ROWS, raw active-high row lines, asynchronous to clock
- col, output, COLS, active-high column drive
- key_code, output, CODE_W, FIFO head code
- key_valid, output, 1, FIFO non-empty
- key_ready, input, 1, consumer accepts head when key_valid&key_ready
- overflow, output, 1, sticky: a code was dropped because the FIFO was full
- busy, output, 1, high in any state other than IDLE

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock.
- Reset values: col = all ones; key_code = 0; key_valid = 0; overflow = 0; busy = 0. FSM goes to IDLE, FIFO empties, synchroniser and counters clear.
- Synchroniser: row passes through 2 flops (rs). All FSM decisions use rs. "any" = |rs.
- IDLE: col = all ones.
  - any=1 -> DEBOUNCE_PRESS, counter cleared.
- DEBOUNCE_PRESS: col = all ones.
  - The counter increments while any=1.
  - any=0 -> IDLE.
  - Counter reaching DEBOUNCE -> SCAN with c=0 and settle counter cleared.
- SCAN: col = one-hot(c).
  - Wait SETTLE cycles, then sample rs.
  - rs!=0: capture r = lowest set bit index of rs, push r*COLS+c, go to HOLD.
  - rs==0 and c<COLS-1: c++, restart settle.
  - rs==0 and c==COLS-1 (key released mid-scan): go to IDLE, no push.
- HOLD: col = all ones.
  - The counter counts consecutive any=0 samples; any=1 clears it.
  - Count reaching DEBOUNCE -> IDLE.
  - Exactly one code is pushed per debounced press.
- Multiple keys:
  - The lowest column wins over higher columns.
  - Within that column, the lowest row wins.
  - Keys pressed while in HOLD are ignored until full release.
- FIFO:
  - Push occurs the cycle after the SCAN sample.
  - key_valid rises 1 cycle after the push.
  - Pop occurs on key_valid&key_ready.
  - Full with push and no pop: the push is dropped and overflow is set.
  - Full with push and pop in the same cycle: both happen and overflow is unchanged.
  - Empty with push and pop in the same cycle: impossible, because key_valid=0.
  - key_code = 0 when empty.
- overflow clears only on reset.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally.
- Reset mid-scan or mid-hold: immediate return to IDLE. Any partially captured code is discarded.
- Latency: row edge -> push = 2 (sync) + DEBOUNCE + (c+1)*SETTLE + small FSM overhead. Implementation documents the exact figure; the bench uses it ±0.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Parameters enabled: REPEAT_DELAY (default 32) and REPEAT_PERIOD (default 8).
- Defined: while in HOLD with any=1 continuously, the captured code is re-pushed after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles. Repeats obey the FIFO full/overflow rules. Release debounce still ends HOLD, and the repeat timer resets on entry to HOLD.
- Undefined: exactly one push per press; the parameters and timer logic are absent.

Test Plan:
1. Reset, then idle for 20 cycles -> col=4'b1111, key_valid=0, overflow=0, busy=0.
2. Hold row=4'b0100 while col[2] is set, for 40 cycles, then release -> one code 10 (2*4+2); key_valid asserts; key_ready=1 pops it; key_valid drops next cycle.
3. Glitch row=4'b0001 for 3 cycles (less than DEBOUNCE) -> FSM returns to IDLE, no push.
4. Press keys at row1/col3 and row2/col1 simultaneously -> single code 9 (col1 wins, row2 -> 2*4+1).
5. With key_ready=0, perform 5 distinct presses (codes 0, 5, 10, 15, 3) -> FIFO holds 0, 5, 10, 15; overflow=1; draining yields those 4 in order.
6. Assert reset during SCAN of c=2 -> col=4'b1111 immediately, FIFO empty, no code emitted.
7. With KEYPAD_AUTOREPEAT_EN, hold code 6 for 60 cycles in HOLD -> pushes at entry, then +32, then +40, then +48.
